// File: rtl/grid_actor_mover.sv
// Tile-grid movement engine for maze actors.
// One shared map lookup is swept serially over all actors per move tick.
module grid_actor_mover #(
  parameter int MAP_W   = 18,
  parameter int MAP_H   = 5,
  parameter int N_ACT   = 3,
  parameter int COORD_W = 5,
  parameter int WRAP    = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [MAP_W*MAP_H-1:0]     map,
  input  logic                       enable,
  input  logic                       tick,
  input  logic                       reload,
  input  logic [2*N_ACT-1:0]         dir,
  input  logic [N_ACT-1:0]           go_home,
  input  logic [COORD_W*N_ACT-1:0]   home_x,
  input  logic [COORD_W*N_ACT-1:0]   home_y,
  output logic [COORD_W*N_ACT-1:0]   pos_x,
  output logic [COORD_W*N_ACT-1:0]   pos_y,
  output logic [N_ACT-1:0]           blocked,
  output logic                       busy,
  output logic                       done
);

  localparam int IDX_W = (N_ACT > 1) ? $clog2(N_ACT) : 1;
  localparam int MI_W  = $clog2(MAP_W * MAP_H);
  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(MAP_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(MAP_H - 1);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } state_t;

  state_t state, state_n;

  logic [IDX_W-1:0]   idx;
  logic [COORD_W-1:0] px [N_ACT];
  logic [COORD_W-1:0] py [N_ACT];
  logic [COORD_W-1:0] hx [N_ACT];
  logic [COORD_W-1:0] hy [N_ACT];
  logic [1:0]         dir_s [N_ACT];
  logic [N_ACT-1:0]   gh_s;
  logic [N_ACT-1:0]   blk;
  logic               start;
  logic               last;

  logic [COORD_W-1:0] cx, cy, tx, ty;
  logic [1:0]         cd;
  logic               edge_hit;
  logic               in_b;
  logic               wall;
  logic               move_ok;
  logic [MI_W-1:0]    m_idx;

  for (genvar k = 0; k < N_ACT; k++) begin : g_pack
    assign hx[k] = home_x[COORD_W*k +: COORD_W];
    assign hy[k] = home_y[COORD_W*k +: COORD_W];
    assign pos_x[COORD_W*k +: COORD_W] = px[k];
    assign pos_y[COORD_W*k +: COORD_W] = py[k];
  end

  assign start   = tick & enable;
  assign last    = (idx == IDX_W'(N_ACT - 1));
  assign blocked = blk;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst || reload) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // DONE also accepts a tick so back-to-back sweeps lose no cycle.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = SWEEP;
      SWEEP:   if (last) state_n = DONE;
      DONE:    state_n = start ? SWEEP : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Bounds are checked on the current coordinate before any wrap.
  always_comb begin
    cx       = px[idx];
    cy       = py[idx];
    cd       = dir_s[idx];
    tx       = cx;
    ty       = cy;
    edge_hit = 1'b0;
    unique case (cd)
      2'b00: begin
        if (cy == '0) begin
          edge_hit = 1'b1;
          ty       = Y_MAX;
        end else begin
          ty = cy - 1'b1;
        end
      end
      2'b01: begin
        if (cy >= Y_MAX) begin
          edge_hit = 1'b1;
          ty       = '0;
        end else begin
          ty = cy + 1'b1;
        end
      end
      2'b10: begin
        if (cx == '0) begin
          edge_hit = 1'b1;
          tx       = X_MAX;
        end else begin
          tx = cx - 1'b1;
        end
      end
      default: begin
        if (cx >= X_MAX) begin
          edge_hit = 1'b1;
          tx       = '0;
        end else begin
          tx = cx + 1'b1;
        end
      end
    endcase
    in_b    = (tx <= X_MAX) && (ty <= Y_MAX);
    m_idx   = MI_W'(tx) + MI_W'(ty) * MI_W'(MAP_W);
    wall    = in_b ? map[m_idx] : 1'b1;
    move_ok = in_b && !wall && (!edge_hit || (WRAP != 0));
  end

  always_ff @(posedge clk) begin
    if (rst || reload) begin
      for (int k = 0; k < N_ACT; k++) begin
        px[k]    <= hx[k];
        py[k]    <= hy[k];
        dir_s[k] <= 2'b00;
      end
      blk  <= '0;
      gh_s <= '0;
      idx  <= '0;
    end else begin
      if ((state != SWEEP) && start) begin
        for (int k = 0; k < N_ACT; k++) begin
          dir_s[k] <= dir[2*k +: 2];
        end
        gh_s <= go_home;
        idx  <= '0;
      end
      if (state == SWEEP) begin
        idx <= last ? '0 : idx + 1'b1;
        if (gh_s[idx]) begin
          px[idx]  <= hx[idx];
          py[idx]  <= hy[idx];
          blk[idx] <= 1'b0;
        end else if (move_ok) begin
          px[idx]  <= tx;
          py[idx]  <= ty;
          blk[idx] <= 1'b0;
        end else begin
          blk[idx] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_grid_actor_mover.sv
// Directed bench for grid_actor_mover.
// Two instances share stimulus: edges blocking and edges wrapping.
module tb_grid_actor_mover;

  logic        clk = 1'b0;
  logic        rst;
  logic [89:0] map;
  logic        enable;
  logic        tick;
  logic        reload;
  logic [5:0]  dir;
  logic [2:0]  go_home;
  logic [14:0] home_x;
  logic [14:0] home_y;
  logic [14:0] pos_x, pos_y, pos_x_w, pos_y_w;
  logic [2:0]  blocked, blocked_w;
  logic        busy, done, busy_w, done_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  grid_actor_mover #(.WRAP(0)) dut (
    .clk(clk), .rst(rst), .map(map), .enable(enable),
    .tick(tick), .reload(reload), .dir(dir),
    .go_home(go_home), .home_x(home_x), .home_y(home_y),
    .pos_x(pos_x), .pos_y(pos_y), .blocked(blocked),
    .busy(busy), .done(done)
  );

  grid_actor_mover #(.WRAP(1)) dut_w (
    .clk(clk), .rst(rst), .map(map), .enable(enable),
    .tick(tick), .reload(reload), .dir(dir),
    .go_home(go_home), .home_x(home_x), .home_y(home_y),
    .pos_x(pos_x_w), .pos_y(pos_y_w), .blocked(blocked_w),
    .busy(busy_w), .done(done_w)
  );

  function automatic logic [4:0] fld(input logic [14:0] v, input int k);
    return v[k*5 +: 5];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic sweep();
    pulse_tick();
    repeat (4) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (pos_x !== {5'd8, 5'd0, 5'd5} || pos_y !== {5'd2, 5'd0, 5'd0}) begin
      errors++;
      $display("FAIL reset_pos got x=%h y=%h", pos_x, pos_y);
    end
    checks++;
    if (blocked !== 3'b000 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got blk=%b busy=%b done=%b exp 000 0 0",
               blocked, busy, done);
    end
  endtask

  task automatic test_wall();
    dir = {2'b00, 2'b10, 2'b11};
    pulse_tick();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL wall_busy got busy=%b done=%b exp 1 0", busy, done);
    end
    step();
    checks++;
    if (fld(pos_x, 0) !== 5'd5 || blocked[0] !== 1'b1) begin
      errors++;
      $display("FAIL wall_a0 got x=%0d blk=%b exp 5 1", fld(pos_x, 0), blocked[0]);
    end
    step();
    checks++;
    if (fld(pos_x, 1) !== 5'd0 || blocked[1] !== 1'b1) begin
      errors++;
      $display("FAIL edge_nowrap got x=%0d blk=%b exp 0 1", fld(pos_x, 1), blocked[1]);
    end
    checks++;
    if (fld(pos_x_w, 1) !== 5'd17 || fld(pos_y_w, 1) !== 5'd0 || blocked_w[1] !== 1'b0) begin
      errors++;
      $display("FAIL edge_wrap got x=%0d y=%0d blk=%b exp 17 0 0",
               fld(pos_x_w, 1), fld(pos_y_w, 1), blocked_w[1]);
    end
    step();
    checks++;
    if (fld(pos_y, 2) !== 5'd1 || done !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wall_a2_done got y=%0d done=%b busy=%b exp 1 1 1",
               fld(pos_y, 2), done, busy);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wall_end got done=%b busy=%b exp 0 0", done, busy);
    end
  endtask

  task automatic test_left();
    int n_done;
    dir = {2'b01, 2'b10, 2'b10};
    n_done = 0;
    pulse_tick();
    repeat (4) begin
      if (done) n_done++;
      step();
    end
    checks++;
    if (fld(pos_x, 0) !== 5'd4 || blocked[0] !== 1'b0) begin
      errors++;
      $display("FAIL left_a0 got x=%0d blk=%b exp 4 0", fld(pos_x, 0), blocked[0]);
    end
    checks++;
    if (fld(pos_x_w, 1) !== 5'd16 || fld(pos_x, 1) !== 5'd0 || fld(pos_y, 2) !== 5'd2) begin
      errors++;
      $display("FAIL left_others got wx1=%0d x1=%0d y2=%0d exp 16 0 2",
               fld(pos_x_w, 1), fld(pos_x, 1), fld(pos_y, 2));
    end
    checks++;
    if (n_done != 1) begin
      errors++;
      $display("FAIL left_done_count got %0d exp 1", n_done);
    end
  endtask

  task automatic test_go_home();
    home_x[14:10] = 5'd10;
    home_y[14:10] = 5'd4;
    go_home = 3'b100;
    sweep();
    go_home = 3'b000;
    checks++;
    if (fld(pos_x, 2) !== 5'd10 || fld(pos_y, 2) !== 5'd4 || blocked[2] !== 1'b0) begin
      errors++;
      $display("FAIL home_first got (%0d,%0d) blk=%b exp (10,4) 0",
               fld(pos_x, 2), fld(pos_y, 2), blocked[2]);
    end
    sweep();
    checks++;
    if (blocked[2] !== 1'b1 || fld(pos_y, 2) !== 5'd4) begin
      errors++;
      $display("FAIL bottom_edge got y=%0d blk=%b exp 4 1", fld(pos_y, 2), blocked[2]);
    end
    checks++;
    if (fld(pos_y_w, 2) !== 5'd0 || blocked_w[2] !== 1'b0) begin
      errors++;
      $display("FAIL bottom_wrap got y=%0d blk=%b exp 0 0", fld(pos_y_w, 2), blocked_w[2]);
    end
    home_x[14:10] = 5'd8;
    home_y[14:10] = 5'd2;
    go_home = 3'b100;
    pulse_tick();
    go_home = 3'b000;
    step();
    step();
    checks++;
    if (fld(pos_x, 2) !== 5'd10 || fld(pos_y, 2) !== 5'd4) begin
      errors++;
      $display("FAIL home_early got (%0d,%0d) exp (10,4)", fld(pos_x, 2), fld(pos_y, 2));
    end
    step();
    checks++;
    if (fld(pos_x, 2) !== 5'd8 || fld(pos_y, 2) !== 5'd2 || blocked[2] !== 1'b0) begin
      errors++;
      $display("FAIL home_snapshot got (%0d,%0d) blk=%b exp (8,2) 0",
               fld(pos_x, 2), fld(pos_y, 2), blocked[2]);
    end
    checks++;
    if (fld(pos_x_w, 2) !== 5'd8 || fld(pos_y_w, 2) !== 5'd2) begin
      errors++;
      $display("FAIL home_wrapdut got (%0d,%0d) exp (8,2)", fld(pos_x_w, 2), fld(pos_y_w, 2));
    end
    step();
  endtask

  task automatic test_back_to_back();
    int n_done;
    dir = {2'b00, 2'b10, 2'b11};
    n_done = 0;
    tick = 1'b1;
    repeat (3) begin
      step();
      if (done) n_done++;
    end
    tick = 1'b0;
    step();
    checks++;
    if (done !== 1'b1 || n_done != 0) begin
      errors++;
      $display("FAIL b2b_first got done=%b early=%0d exp 1 0", done, n_done);
    end
    tick = 1'b1;
    step();
    tick = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_restart got busy=%b done=%b exp 1 0", busy, done);
    end
    repeat (3) step();
    checks++;
    if (done !== 1'b1 || fld(pos_x, 0) !== 5'd3) begin
      errors++;
      $display("FAIL b2b_second got done=%b x0=%0d exp 1 3", done, fld(pos_x, 0));
    end
    step();
  endtask

  task automatic test_reload();
    int n_done;
    n_done = 0;
    pulse_tick();
    reload = 1'b1;
    step();
    reload = 1'b0;
    checks++;
    if (busy !== 1'b0 || blocked !== 3'b000 || blocked_w !== 3'b000) begin
      errors++;
      $display("FAIL reload_flags got busy=%b blk=%b wblk=%b exp 0 000 000",
               busy, blocked, blocked_w);
    end
    checks++;
    if (pos_x !== {5'd8, 5'd0, 5'd5} || pos_y !== {5'd2, 5'd0, 5'd0} ||
        pos_x_w !== {5'd8, 5'd0, 5'd5}) begin
      errors++;
      $display("FAIL reload_pos got x=%h y=%h wx=%h", pos_x, pos_y, pos_x_w);
    end
    repeat (4) begin
      if (done || busy) n_done++;
      step();
    end
    checks++;
    if (n_done != 0) begin
      errors++;
      $display("FAIL reload_nodone got %0d active cycles exp 0", n_done);
    end
  endtask

  task automatic test_enable_off();
    enable = 1'b0;
    dir = {2'b01, 2'b11, 2'b10};
    pulse_tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL disabled_busy got %b exp 0", busy);
    end
    repeat (4) step();
    checks++;
    if (pos_x !== {5'd8, 5'd0, 5'd5} || pos_y !== {5'd2, 5'd0, 5'd0}) begin
      errors++;
      $display("FAIL disabled_pos got x=%h y=%h", pos_x, pos_y);
    end
    enable = 1'b1;
  endtask

  initial begin
    map     = '0;
    map[6]  = 1'b1;
    map[11] = 1'b1;
    rst     = 1'b1;
    enable  = 1'b1;
    tick    = 1'b0;
    reload  = 1'b0;
    dir     = '0;
    go_home = '0;
    home_x  = {5'd8, 5'd0, 5'd5};
    home_y  = {5'd2, 5'd0, 5'd0};
    #2;
    test_reset();
    test_wall();
    test_left();
    test_go_home();
    test_back_to_back();
    test_reload();
    test_enable_off();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
